// File: rtl/serial_parallel_pkg.sv
// ============================================================================
// Module   : serial_parallel_pkg
// Brief    : Shared types and constants for the serial-to-parallel receiver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_parallel_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_parallel_sync_match.sv
// ============================================================================
// Module   : sync_match
// Brief    : Combinational compare of the incoming shift window against SYNC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_match
    import serial_parallel_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC = SYNC_DEFAULT
) (
    input  logic [BYTE_W-2:0] sr,
    input  logic              din,
    output logic              match
);

    assign match = ({sr, din} == SYNC);

endmodule

`default_nettype wire

// File: rtl/serial_parallel.sv
// ============================================================================
// Module   : serial_parallel
// Brief    : MSB-first serial byte receiver with sync-byte hunt and lock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_parallel
    import serial_parallel_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              din,
    input  logic              hunt,
    output logic [BYTE_W-1:0] data_o,
    output logic              valid,
    output logic              locked,
    output logic              sync_det,
    output logic [BYTE_W-1:0] byte_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    // Only the low seven bits are ever read back; the oldest bit falls off.
    logic [BYTE_W-2:0] r_sr;
    logic [2:0]        r_bit_cnt;
    logic [2:0]        w_bit_cnt_nxt;
    logic              w_match;
    logic              w_capture;
    logic              w_sync_hit;

    sync_match #(
        .SYNC (SYNC)
    ) u_sync_match (
        .sr    (r_sr),
        .din   (din),
        .match (w_match)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= HUNT;
            r_bit_cnt <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    // hunt overrides both a pending capture and a pending sync match.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_capture     = 1'b0;
        w_sync_hit    = 1'b0;
        if (hunt) begin
            w_state_nxt   = HUNT;
            w_bit_cnt_nxt = 3'd0;
        end else if (en) begin
            case (r_state)
                HUNT: begin
                    if (w_match) begin
                        w_state_nxt   = LOCKED;
                        w_bit_cnt_nxt = 3'd0;
                        w_sync_hit    = 1'b1;
                    end
                end
                LOCKED: begin
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    w_capture     = (r_bit_cnt == 3'd7);
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr     <= '0;
            data_o   <= '0;
            valid    <= 1'b0;
            sync_det <= 1'b0;
            locked   <= 1'b0;
            byte_cnt <= '0;
        end else begin
            if (en) begin
                r_sr <= {r_sr[BYTE_W-3:0], din};
            end
            if (w_capture) begin
                data_o   <= {r_sr, din};
                byte_cnt <= byte_cnt + 8'd1;
            end
            valid    <= w_capture;
            sync_det <= w_sync_hit;
            locked   <= (w_state_nxt == LOCKED);
        end
    end

endmodule

`default_nettype wire
